// File: rtl/cvmcu_dbg_halt_ctrl.sv
// cvmcu_dbg_halt_ctrl: filters debug_req_i, runs the core halt/resume handshake
// with a bounded acknowledge window, and stops the system timer while halted.
module cvmcu_dbg_halt_ctrl #(
    parameter int unsigned REQ_FILTER   = 2,
    parameter int unsigned HALT_TIMEOUT = 256,
    parameter bit          STOPTIMER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        debug_req_i,
    input  logic        core_halted_i,
    input  logic        resume_req_i,
    input  logic        timeout_clr_i,
    output logic        core_debug_halt_o,
    output logic        core_resume_o,
    output logic        stoptimer_o,
    output logic        timeout_o,
    output logic [15:0] halt_count_o,
    output logic [1:0]  dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, HALT_REQ = 2'd1, HALTED = 2'd2, RESUME = 2'd3} state_e;
    localparam logic [3:0]  FILT_LAST = 4'(REQ_FILTER - 1);
    localparam logic [15:0] TMO_LAST  = 16'(HALT_TIMEOUT - 1);
    state_e      state_q, state_d;
    logic [3:0]  filt_q, filt_d;
    logic [15:0] tmo_q, tmo_d, cnt_q, cnt_d;
    logic        timeout_q, timeout_d, set_to;
    logic        tmo_hit;
    assign tmo_hit = tmo_q == TMO_LAST;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            filt_q    <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        set_to  = 1'b0;
        case (state_q)
            IDLE: begin
                filt_d = debug_req_i ? filt_q + 4'd1 : 4'd0;
                if (debug_req_i && filt_q == FILT_LAST) begin
                    state_d = HALT_REQ;
                    filt_d  = '0;
                    tmo_d   = '0;
                end
            end
            HALT_REQ: begin
                if (core_halted_i) begin
                    state_d = HALTED;
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    set_to  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            HALTED: begin
                // a core leaving debug mode on its own overrides a pending resume
                if (!core_halted_i) begin
                    state_d = IDLE;
                end else if (resume_req_i) begin
                    state_d = RESUME;
                    tmo_d   = '0;
                end
            end
            default: begin
                if (!core_halted_i) begin
                    state_d = IDLE;
                    filt_d  = '0;
                end else if (tmo_hit) begin
                    state_d = HALTED;
                    set_to  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
        endcase
        timeout_d = set_to | (timeout_q & ~timeout_clr_i);
    end
    always_comb begin
        core_debug_halt_o = state_q == HALT_REQ;
        core_resume_o     = state_q == RESUME;
        stoptimer_o       = STOPTIMER_EN && (state_q == HALTED || state_q == RESUME);
        timeout_o         = timeout_q;
        halt_count_o      = cnt_q;
        dbg_state_o       = state_q;
    end
endmodule

// File: tb/tb_cvmcu_dbg_halt_ctrl.sv
// tb_cvmcu_dbg_halt_ctrl: vector table, corner sequences and randomized model check.
module tb_cvmcu_dbg_halt_ctrl;
    localparam int RF = 2;
    localparam int HT = 8;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        debug_req = 1'b0, core_halted = 1'b0, resume_req = 1'b0, timeout_clr = 1'b0;
    logic        halt_o, resume_o, stop_o, to_o;
    logic [15:0] cnt_o;
    logic [1:0]  st_o;
    int          errors = 0;
    int          checks = 0;
    int          m_mode = 0, m_run = 0, m_wait = 0, m_cnt = 0;
    bit          m_to = 1'b0;

    cvmcu_dbg_halt_ctrl #(.REQ_FILTER(RF), .HALT_TIMEOUT(HT), .STOPTIMER_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .debug_req_i(debug_req), .core_halted_i(core_halted),
        .resume_req_i(resume_req), .timeout_clr_i(timeout_clr), .core_debug_halt_o(halt_o),
        .core_resume_o(resume_o), .stoptimer_o(stop_o), .timeout_o(to_o),
        .halt_count_o(cnt_o), .dbg_state_o(st_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n, req, hlt, res, clr;
        logic [1:0] st;
        bit to;
        logic [15:0] cnt;
    } vec_t;
    vec_t vq[$];

    task automatic add(input bit rst_n, req, hlt, res, clr, input logic [1:0] st, input bit to, input logic [15:0] cnt);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.hlt = hlt; v.res = res; v.clr = clr;
        v.st = st; v.to = to; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Moore outputs follow from the expected state by the decode rules
    task automatic chk_st(input string name, input logic [1:0] st, input bit to, input logic [15:0] cnt);
        chk({name, ".state"}, 32'(st_o), 32'(st));
        chk({name, ".halt"}, 32'(halt_o), 32'(st == 2'd1));
        chk({name, ".resume"}, 32'(resume_o), 32'(st == 2'd3));
        chk({name, ".stoptimer"}, 32'(stop_o), 32'(st >= 2'd2));
        chk({name, ".timeout"}, 32'(to_o), 32'(to));
        chk({name, ".count"}, 32'(cnt_o), 32'(cnt));
    endtask

    // Behavioural view: how long the request has been held, how long the core has kept us waiting
    task automatic model_edge();
        bit set = 1'b0;
        if (!reset_n) begin
            m_mode = 0; m_run = 0; m_wait = 0; m_cnt = 0; m_to = 1'b0;
            return;
        end
        if (m_mode == 0) begin
            m_run = debug_req ? m_run + 1 : 0;
            if (m_run == RF) begin m_mode = 1; m_run = 0; m_wait = 0; end
        end else if (m_mode == 1) begin
            if (core_halted) begin
                m_mode = 2;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end else begin
                m_wait++;
                if (m_wait == HT) begin set = 1'b1; m_mode = 0; end
            end
        end else if (m_mode == 2) begin
            if (!core_halted) m_mode = 0;
            else if (resume_req) begin m_mode = 3; m_wait = 0; end
        end else begin
            if (!core_halted) begin m_mode = 0; m_run = 0; end
            else begin
                m_wait++;
                if (m_wait == HT) begin set = 1'b1; m_mode = 2; end
            end
        end
        m_to = set ? 1'b1 : (timeout_clr ? 1'b0 : m_to);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rst_n, req, hlt, res, clr);
        reset_n = rst_n; debug_req = req; core_halted = hlt; resume_req = res; timeout_clr = clr;
    endtask

    initial begin
        add(0,0,0,0,0, 0,0,0);
        add(1,1,0,0,0, 0,0,0);
        add(1,0,0,0,0, 0,0,0);
        add(1,1,0,0,0, 0,0,0);
        add(1,0,0,0,0, 0,0,0);
        add(1,1,0,0,0, 0,0,0);
        add(1,1,0,0,0, 1,0,0);
        add(1,0,0,0,0, 1,0,0);
        add(1,0,0,0,0, 1,0,0);
        add(1,0,1,0,0, 2,0,1);
        add(1,1,1,0,0, 2,0,1);
        add(1,0,1,1,0, 3,0,1);
        add(1,0,1,0,0, 3,0,1);
        add(1,0,0,0,0, 0,0,1);
        add(1,0,0,0,0, 0,0,1);
        add(1,1,0,0,0, 0,0,1);
        add(1,1,0,0,0, 1,0,1);
        for (int i = 0; i < HT - 1; i++) add(1,0,0,0,0, 1,0,1);
        add(1,0,0,0,0, 0,1,1);
        add(1,0,0,0,1, 0,0,1);
        add(1,1,0,0,0, 0,0,1);
        add(1,1,0,0,0, 1,0,1);
        for (int i = 0; i < HT - 1; i++) add(1,0,0,0,0, 1,0,1);
        add(1,0,1,0,0, 2,0,2);
        add(1,0,0,1,0, 0,0,2);
        add(1,1,0,0,0, 0,0,2);
        add(1,1,0,0,0, 1,0,2);
        add(1,0,1,0,0, 2,0,3);
        add(1,0,1,1,0, 3,0,3);
        for (int i = 0; i < HT - 1; i++) add(1,0,1,0,0, 3,0,3);
        add(1,0,1,0,1, 2,1,3);
        add(1,0,1,0,1, 2,0,3);
        add(0,0,1,0,0, 0,0,0);
        add(1,0,0,0,0, 0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst_n, vq[i].req, vq[i].hlt, vq[i].res, vq[i].clr);
            tick();
            chk_st($sformatf("vec%0d", i), vq[i].st, vq[i].to, vq[i].cnt);
        end

        // level request held across a spontaneous exit re-halts after the filter delay
        drive(1,1,0,0,0); tick(); chk_st("rehalt.f1", 0, 0, 0);
        tick();                   chk_st("rehalt.req", 1, 0, 0);
        drive(1,1,1,0,0); tick(); chk_st("rehalt.ack", 2, 0, 1);
        drive(1,1,0,0,0); tick(); chk_st("rehalt.exit", 0, 0, 1);
        tick();                   chk_st("rehalt.f2", 0, 0, 1);
        tick();                   chk_st("rehalt.again", 1, 0, 1);
        drive(0,1,0,0,0); tick(); chk_st("rst_midreq", 0, 0, 0);
        drive(1,0,0,0,0); tick(); chk_st("rst_after", 0, 0, 0);

        dut.cnt_q = 16'hFFFE;
        m_cnt = 65534;
        for (int k = 0; k < 2; k++) begin
            drive(1,1,0,0,0); tick(); tick();
            chk_st($sformatf("sat%0d.req", k), 1, 0, 16'hFFFE + 16'(k));
            drive(1,0,1,0,0); tick();
            chk_st($sformatf("sat%0d.ack", k), 2, 0, 16'hFFFF);
            drive(1,0,0,0,0); tick();
            chk_st($sformatf("sat%0d.exit", k), 0, 0, 16'hFFFF);
        end

        for (int c = 0; c < 4000; c++) begin
            reset_n = $urandom_range(0, 199) != 0;
            if ($urandom_range(0, 3) == 0) debug_req = ~debug_req;
            if ($urandom_range(0, 2) == 0) core_halted = ~core_halted;
            resume_req = $urandom_range(0, 3) == 0;
            timeout_clr = $urandom_range(0, 15) == 0;
            tick();
            chk_st($sformatf("rand%0d", c), 2'(m_mode), m_to, 16'(m_cnt));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cvmcu_dbg_halt_ctrl.md
# cvmcu_dbg_halt_ctrl

- **Role:** core-side responder for the CORE-V-MCU debug interface. The system side drives `debug_req_i`; this block answers it.
- **Function:** filters and latches `debug_req_i`, runs the halt/resume handshake with the core, and drives `stoptimer_o` while the core is in debug mode.
- **Placement:** sits between the debug request line and the core debug port. It is the RTL counterpart of the core-side driver in the debug agent.

## Interface
Parameters:
- `REQ_FILTER`, 2: consecutive sampled-high cycles of `debug_req_i` required to start a halt; legal range 1..15.
- `HALT_TIMEOUT`, 256: maximum cycles allowed for the core to acknowledge a halt or resume; legal range 2..65535.
- `STOPTIMER_EN`, 1: 0 ties `stoptimer_o` low.

Ports:
- `clk`  in  1  single clock; all logic samples on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `debug_req_i`  in  1  level debug request from the system side.
- `core_halted_i`  in  1  core reports it is in debug mode.
- `resume_req_i`  in  1  debugger resume request, level or pulse.
- `timeout_clr_i`  in  1  clears `timeout_o`.
- `core_debug_halt_o`  out  1  halt request to the core.
- `core_resume_o`  out  1  resume request to the core.
- `stoptimer_o`  out  1  stops the system timer while debugging.
- `timeout_o`  out  1  sticky handshake-timeout flag.
- `halt_count_o`  out  16  number of completed halts, saturating.
- `dbg_state_o`  out  2  current state: IDLE=0, HALT_REQ=1, HALTED=2, RESUME=3.

## Operation
- **Reset.** While `reset_n`=0 at a posedge:
  - state <= IDLE.
  - Filter counter, timeout counter and `halt_count_o` <= 0.
  - `timeout_o` <= 0.
  - All outputs are 0 from the following cycle.
  - Reset mid-handshake aborts immediately. No resume is issued.
- **Outputs.**
  - All outputs are Moore decodes of registered state, or direct registers.
  - `core_debug_halt_o` = (state==HALT_REQ).
  - `core_resume_o` = (state==RESUME).
  - `stoptimer_o` = STOPTIMER_EN & (state==HALTED | state==RESUME).
- **IDLE.**
  - 4-bit filter counter increments on each edge where `debug_req_i`=1, and clears on any edge where it is 0.
  - The edge that sees `debug_req_i`=1 with the counter at REQ_FILTER-1 moves to HALT_REQ. The filter and timeout counters clear.
- **HALT_REQ.**
  - The request is latched: a later drop of `debug_req_i` does not cancel it.
  - `core_halted_i`=1: go to HALTED; `halt_count_o` += 1, saturating at 0xFFFF.
  - Otherwise the timeout counter increments. On the edge where it equals HALT_TIMEOUT-1: set `timeout_o`, go to IDLE.
  - If ack and timeout occur on the same edge, the ack wins.
- **HALTED.**
  - `debug_req_i` is ignored.
  - Priority 1: `core_halted_i`=0 (spontaneous exit) goes to IDLE.
  - Priority 2: `resume_req_i`=1 goes to RESUME and clears the timeout counter.
- **RESUME.**
  - `core_halted_i`=0: go to IDLE and clear the filter counter.
  - Otherwise count. At HALT_TIMEOUT-1: set `timeout_o`, return to HALTED.
- **Re-halt.** `debug_req_i` still high after returning to IDLE re-halts after REQ_FILTER cycles (level semantics).
- **timeout_o.**
  - Sticky. Cleared by `timeout_clr_i`=1 or by reset.
  - If set and clear occur on the same edge, set wins.

## Timing
- **Halt latency.** `debug_req_i` high at edges 1..REQ_FILTER gives `core_debug_halt_o`=1 after edge REQ_FILTER, i.e. REQ_FILTER cycles.
- **Ack to halted.** `core_halted_i` sampled high at edge k:
  - after edge k: `core_debug_halt_o`=0 and `stoptimer_o`=1;
  - `halt_count_o` updates at edge k.
- **Resume.** `resume_req_i` sampled at edge k gives `core_resume_o`=1 after edge k. `core_halted_i`=0 sampled at edge m:
  - after edge m: `core_resume_o`=0 and `stoptimer_o`=0.
- **Timeout window.** With no ack, `core_debug_halt_o` stays high for exactly HALT_TIMEOUT cycles, and `timeout_o` rises with the drop.
- **Counter widths.**
  - Timeout counter: 16 bits.
  - `halt_count_o` saturates and never wraps.
- **Inputs.** No combinational input-to-output paths. Inputs are synchronous to `clk`.

## Test plan
- **Reset values.** Assert `reset_n`=0 mid-HALTED -> next cycle all outputs 0 and `dbg_state_o`=0. `halt_count_o` stays 0 until a new halt.
- **Filter.** REQ_FILTER=2:
  - Pulse `debug_req_i` for 1 cycle -> no halt.
  - Hold for 2 cycles -> `core_debug_halt_o` high after the 2nd edge.
  - Glitch pattern 1,0,1 -> no halt.
- **Full cycle.**
  - Core acks 3 cycles after the halt request -> `stoptimer_o`=1 and `halt_count_o`=1.
  - `resume_req_i` pulse -> `core_resume_o`=1 until `core_halted_i` falls, then all low and state=0.
- **Timeout.** HALT_TIMEOUT=8 with no ack:
  - `core_debug_halt_o` high for exactly 8 cycles, then `timeout_o`=1 and state=IDLE.
  - Ack on the 8th edge -> HALTED and no timeout.
  - `timeout_clr_i` -> `timeout_o`=0.
- **Simultaneous events.** In HALTED, assert `resume_req_i`=1 and `core_halted_i`=0 on the same edge -> IDLE, `core_resume_o` never asserted.
- **Saturation.** Force 65536 halts (or preload `halt_count_o` to 0xFFFE via hierarchical deposit) -> count reaches 0xFFFF and holds on further halts.
